// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared widths and tagged-sample type for the accumulator datapath
//
// Purpose: common constants for the accumulator stage and its consumers, plus
//          the {seq, data} sample record that travels through the decimator FIFO.
// Contents:
//   ACC_W         accumulator sum width
//   SEQ_W         sample sequence-number width
//   acc_sample_t  packed {seq, data}; seq occupies the upper bits
//   make_sample   builds an acc_sample_t from its fields
package acc_pkg;

  localparam int ACC_W = 8;
  localparam int SEQ_W = 4;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [ACC_W-1:0] data;
  } acc_sample_t;

  function automatic acc_sample_t make_sample(input logic [SEQ_W-1:0] s,
                                              input logic [ACC_W-1:0] d);
    acc_sample_t r_s;
    r_s.seq  = s;
    r_s.data = d;
    return r_s;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - synchronous first-word-fall-through FIFO
//
// Purpose: small register-array FIFO whose head entry is always presented on
//          rd_data while not empty; rd_en acknowledges (consumes) that head.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset; clears pointers and storage
//   wr_en    in   write request; accepted when not full, or when full and a
//                 read is accepted in the same cycle
//   wr_data  in   W-bit write data
//   rd_en    in   consume the head entry (ignored when empty)
//   rd_data  out  W-bit head entry
//   empty    out  no entries stored
//   full     out  DEPTH entries stored
//   level    out  occupancy, 0..DEPTH
module sync_fifo_fwft #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  // Counters carry one extra bit so full and empty differ when pointers match.
  logic [AW:0]  r_wr_cnt;
  logic [AW:0]  r_rd_cnt;

  logic [AW:0]  w_level;
  logic         w_rd_ok;
  logic         w_wr_ok;

  assign w_level = r_wr_cnt - r_rd_cnt;
  assign level   = w_level;
  assign empty   = (w_level == '0);
  assign full    = (w_level == (AW+1)'(DEPTH));
  assign rd_data = r_mem[r_rd_cnt[AW-1:0]];

  assign w_rd_ok = rd_en & ~empty;
  // When full, the write slot equals the head slot being consumed this edge,
  // so the new entry lands behind everything still queued.
  assign w_wr_ok = wr_en & (~full | w_rd_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr_ok) begin
        r_mem[r_wr_cnt[AW-1:0]] <= wr_data;
        r_wr_cnt                <= r_wr_cnt + 1'b1;
      end
      if (w_rd_ok) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/acc_decimator_fifo.sv
// rtl/acc_decimator_fifo.sv - decimating sampler of the accumulator sum with tagged FWFT output queue
//
// Purpose: samples acc_in once every PERIOD enabled cycles, tags each sample
//          with a wrapping sequence number and queues it for a valid/ready
//          consumer. Samples arriving while the queue is full (and not being
//          drained) are dropped; the sequence number still advances so the gap
//          is visible downstream, and a sticky overflow flag is raised.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   en       in   advance the decimation phase counter
//   acc_in   in   WIDTH-bit accumulator sum, captured on the strobe edge
//   m_data   out  {seq[3:0], sample[WIDTH-1:0]} at the queue head
//   m_valid  out  queue not empty
//   m_ready  in   consumer accepts m_data when m_valid & m_ready
//   level    out  queue occupancy
//   overflow out  sticky drop flag
//   clr_ovf  in   synchronous clear of overflow (a same-cycle drop wins)
module acc_decimator_fifo
  import acc_pkg::*;
#(
  parameter int WIDTH  = ACC_W,
  parameter int PERIOD = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [WIDTH-1:0]           acc_in,
  output logic [WIDTH+SEQ_W-1:0]     m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  // A one-bit phase register still works for PERIOD=1: it stays at 0, which
  // equals PHASE_LAST, so every enabled cycle strobes.
  localparam int              PW         = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0]   PHASE_LAST = PW'(PERIOD - 1);

  logic [PW-1:0]              r_phase;
  logic [SEQ_W-1:0]           r_seq;
  logic                       r_overflow;

  logic                       w_strobe;
  logic                       w_pop;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_push_ok;
  logic                       w_drop;
  logic [WIDTH+SEQ_W-1:0]     w_push_data;

  assign w_strobe    = en & (r_phase == PHASE_LAST);
  assign w_push_data = {r_seq, acc_in};

  // m_valid comes straight from stored occupancy, never from m_ready.
  assign m_valid   = ~w_empty;
  assign w_pop     = m_valid & m_ready;
  assign w_push_ok = w_strobe & (~w_full | w_pop);
  assign w_drop    = w_strobe & w_full & ~w_pop;
  assign overflow  = r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else if (en) begin
      r_phase <= (r_phase == PHASE_LAST) ? '0 : r_phase + PW'(1);
    end
  end

  // seq advances on every strobe, accepted or dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq <= '0;
    end else if (w_strobe) begin
      r_seq <= r_seq + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  sync_fifo_fwft #(
    .W     (WIDTH + SEQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_push_ok),
    .wr_data (w_push_data),
    .rd_en   (w_pop),
    .rd_data (m_data),
    .empty   (w_empty),
    .full    (w_full),
    .level   (level)
  );

endmodule

// File: tb/tb_acc_decimator_fifo.sv
// tb/tb_acc_decimator_fifo.sv - self-checking bench for acc_decimator_fifo
module tb_acc_decimator_fifo;
  import acc_pkg::*;

  localparam int PERIOD = 4;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  acc_in;
  logic [11:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  level;
  logic        overflow;
  logic        clr_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of expected samples plus phase/seq/overflow state.
  acc_sample_t sb[$];
  int          mdl_phase;
  logic [3:0]  mdl_seq;
  logic        mdl_ovf;

  typedef struct {
    logic        en;
    logic [7:0]  acc;
    logic        rdy;
    logic        exp_valid;
    int          exp_level;
    logic [11:0] exp_data;
  } vec_t;

  vec_t tbl[13];

  acc_decimator_fifo #(.WIDTH(8), .PERIOD(PERIOD), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .acc_in   (acc_in),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .level    (level),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    mdl_phase = 0;
    mdl_seq   = 4'd0;
    mdl_ovf   = 1'b0;
  endtask

  task automatic drive(input logic e, input logic [7:0] a, input logic r, input logic c);
    en      = e;
    acc_in  = a;
    m_ready = r;
    clr_ovf = c;
  endtask

  task automatic check_state();
    chk("m_valid", int'(m_valid), int'(sb.size() != 0));
    chk("level", int'(level), sb.size());
    chk("overflow", int'(overflow), int'(mdl_ovf));
  endtask

  // Scoreboard update for the coming edge; the popped head is compared here.
  task automatic advance();
    acc_sample_t exp_s;
    logic        drop;
    drop = 1'b0;
    if (sb.size() != 0 && m_ready) begin
      exp_s = sb.pop_front();
      chk("pop_data", int'(m_data), int'(exp_s));
    end
    if (en && mdl_phase == PERIOD - 1) begin
      if (sb.size() < DEPTH) sb.push_back(make_sample(mdl_seq, acc_in));
      else drop = 1'b1;
      mdl_seq++;
    end
    if (drop) mdl_ovf = 1'b1;
    else if (clr_ovf) mdl_ovf = 1'b0;
    if (en) mdl_phase = (mdl_phase == PERIOD - 1) ? 0 : mdl_phase + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic e, input logic [7:0] a, input logic r, input logic c);
    drive(e, a, r, c);
    @(negedge clk);
    check_state();
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Table for the basic stream: acc steps 1..13, en=1, m_ready=1.
    for (int i = 0; i < 13; i++) begin
      tbl[i].en        = 1'b1;
      tbl[i].acc       = 8'(i + 1);
      tbl[i].rdy       = 1'b1;
      tbl[i].exp_valid = 1'b0;
      tbl[i].exp_level = 0;
      tbl[i].exp_data  = 12'h000;
    end
    tbl[4].exp_valid  = 1'b1; tbl[4].exp_level  = 1; tbl[4].exp_data  = 12'h004;
    tbl[8].exp_valid  = 1'b1; tbl[8].exp_level  = 1; tbl[8].exp_data  = 12'h108;
    tbl[12].exp_valid = 1'b1; tbl[12].exp_level = 1; tbl[12].exp_data = 12'h20C;

    rst_n = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    model_reset();
    #12;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_m_data", int'(m_data), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic decimated stream, table driven.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].en, tbl[i].acc, tbl[i].rdy, 1'b0);
      @(negedge clk);
      check_state();
      chk($sformatf("tbl%0d_valid", i), int'(m_valid), int'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].exp_level);
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_data", i), int'(m_data), int'(tbl[i].exp_data));
      advance();
    end

    // Five strobes with consumer stalled: fill, drop seq=4, drain, next seq=5.
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    chk("fill_level", int'(level), 4);
    chk("fill_overflow", int'(overflow), 1);
    repeat (4) cyc(1'b0, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    chk("seq_after_drop", int'(m_data[11:8]), 5);
    chk("data_after_drop", int'(m_data[7:0]), 8'hA3);
    cyc(1'b0, 8'd0, 1'b0, 1'b1);
    repeat (2) cyc(1'b0, 8'd0, 1'b1, 1'b0);

    // Full queue, strobe and pop on the same edge.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    chk("full_level", int'(level), 4);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    cyc(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("push_pop_level", int'(level), 4);
    chk("push_pop_overflow", int'(overflow), 0);
    repeat (3) cyc(1'b0, 8'd0, 1'b1, 1'b0);
    chk("push_pop_last_level", int'(level), 1);
    chk("push_pop_last_data", int'(m_data), 12'h45A);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);

    // Gapped enable 1,0,0,1,...: strobe only on the fourth enabled cycle.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc((i % 3) == 0, 8'(8'h10 + i), 1'b0, 1'b0);
      if (i == 8) chk("gap_no_early_push", int'(level), 0);
    end
    chk("gap_level", int'(level), 1);
    chk("gap_data", int'(m_data), 12'h019);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);

    // clr_ovf colliding with a drop, then clr_ovf alone.
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
    chk("ovf_set_wins", int'(overflow), 1);
    cyc(1'b0, 8'd0, 1'b0, 1'b1);
    chk("ovf_cleared", int'(overflow), 0);
    repeat (4) cyc(1'b0, 8'd0, 1'b1, 1'b0);

    // Asynchronous reset between edges with three entries queued.
    do_reset();
    for (int i = 0; i < 12; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    chk("pre_rst_level", int'(level), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(m_valid), 0);
    chk("async_rst_level", int'(level), 0);
    model_reset();
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    chk("post_rst_valid", int'(m_valid), 1);
    chk("post_rst_data", int'(m_data), 12'h033);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_decimator_fifo.md
# acc_decimator_fifo

Downstream consumer of the accumulator stage. Samples the running 8-bit accumulator sum once every PERIOD enabled cycles, tags each sample with a 4-bit sequence number, and buffers it in a small first-word-fall-through FIFO. A valid/ready handshake presents the samples to the next stage (framer or host interface). Drops on overflow are flagged and remain visible in the sequence numbers.

## Interface
- WIDTH, 8, sample width; matches the accumulator sum width.
- PERIOD, 4, number of enabled cycles between samples; must be ≥1.
- DEPTH, 4, FIFO entries; must be a power of two, ≥2.
- clk  in  1  clock. All logic is rising-edge.
- rst_n  in  1  reset. Asynchronous assertion, active-low.
- en  in  1  advance the decimation phase counter. The counter holds while low.
- acc_in  in  WIDTH  accumulator sum; sampled on the strobe edge.
- m_data  out  WIDTH+4  {seq[3:0], sample[WIDTH-1:0]} at the FIFO head.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts m_data when m_valid & m_ready.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: a strobe occurred while the FIFO was full and no pop occurred.
- clr_ovf  in  1  synchronous clear of overflow.

## Operation
- Phase counter `phase` counts 0..PERIOD-1 and increments only when en=1. The value after PERIOD-1 is 0.
- strobe = en & (phase == PERIOD-1). For PERIOD=1, strobe = en.
- On strobe:
  - push = {seq, acc_in}.
  - seq increments modulo 16 on every strobe, whether or not the push is accepted. Gaps in seq therefore expose drops.
- pop = m_valid & m_ready.
- Push accepted when FIFO not full, or when full and pop occurs in the same cycle.
  - Full with pop: the entry is freed and the new sample is written. level stays at DEPTH.
- Push rejected when full with no pop: the sample is discarded and overflow is set to 1.
- Simultaneous push and pop when not empty: level is unchanged.
- Simultaneous push and pop when empty: impossible by construction, since pop requires m_valid.
- clr_ovf=1 clears overflow. If a drop occurs in the same cycle, set wins and overflow=1.
- m_data is undefined (hold last contents) when m_valid=0. The bench must not check it then.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level is derived from the write-count minus read-count difference using one extra bit.

## Timing
- Reset values: phase=0, seq=0, FIFO empty, m_valid=0, level=0, overflow=0, m_data=0.
- Sample latency: acc_in captured at strobe edge t gives m_valid=1 and m_data={seq,acc_in} from edge t onward, i.e. visible throughout cycle t+1 if the FIFO was empty.
- Head advances on the edge where pop=1. The next entry, if any, is visible the following cycle. There are no bubbles, so sustained throughput is 1 per cycle.
- m_valid never depends combinationally on m_ready.
- level and overflow update on the same edge as the push/pop that changes them.
- Reset asserted mid-operation: all state is cleared asynchronously and buffered samples are lost. The first strobe after release occurs after PERIOD enabled cycles and carries seq=0.

## Structure
- A shared package `acc_pkg` holds ACC_W=8, SEQ_W=4, and the tagged-sample struct typedef `acc_sample_t` {seq, data}.
- The block uses one sub-module, `sync_fifo_fwft`, parameterised by width and depth.
  - It has ports clk, rst_n, wr_en, wr_data, rd_en, rd_data, empty, full, level.
  - All FIFO edge cases live in this sub-module.
- The top level contains the phase counter, seq counter, accept/drop logic and the overflow flag.

## Test plan
- Reset, then en=1 and m_ready=1, with acc_in stepping 1,2,3,... per cycle and PERIOD=4. Required: m_data = {0,4}, {1,8}, {2,12}, one sample every 4 cycles, each appearing 1 cycle after its strobe.
- m_ready=0 for 5 strobes with DEPTH=4. Required: level reaches 4 and overflow=1. After draining, seq reads 0,1,2,3 and the next sample has seq=5, since seq=4 was dropped.
- FIFO full, then a strobe and a pop in the same cycle. Required: no drop, overflow stays 0, level stays 4, and the new entry is last out.
- en toggled 1,0,0,1,... Required: the strobe fires only after 4 cycles with en=1. Cycles with en=0 neither advance phase nor push.
- overflow=1, then clr_ovf=1 coinciding with a new drop. Required: overflow stays 1. Then clr_ovf=1 alone gives overflow=0 the next cycle.
- rst_n pulsed low asynchronously between clock edges with 3 entries buffered. Required: m_valid=0 and level=0 immediately. After release, the first sample carries seq=0.
